traffic_light_monitor: RTL and testbench

- Conflict/timing monitor on the four lamp buses (M1, M2, MT, S) driven by the intersection controller.
- Decodes the lamp pattern back to a phase code and checks lamp encoding, conflicts, phase order and per-phase dwell.
- Latches the first fault and reports it to the supervisor; acts as the malfunction-management unit beside the controller.

---
 rtl/tlm_pkg.sv | 25 ++
 rtl/tlm_phase_decode.sv | 30 +++
 rtl/traffic_light_monitor.sv | 134 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlm_pkg.sv
// tlm_pkg: lamp encodings, phase codes, fault codes, monitor states and phase order
// shared by the traffic light monitor.
package tlm_pkg;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [2:0] P_NONE = 3'd0;
    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P4 = 3'd4;
    localparam logic [2:0] P5 = 3'd5;
    localparam logic [2:0] P6 = 3'd6;

    typedef enum logic [2:0] {
        F_NONE, F_ENC, F_CONFLICT, F_UNKNOWN, F_SEQ, F_SHORT, F_LONG
    } fault_e;

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_e;

    function automatic logic [2:0] next_phase(input logic [2:0] p);
        return (p == P6) ? P1 : p + 3'd1;
    endfunction
endpackage

// File: rtl/tlm_phase_decode.sv
// tlm_phase_decode: maps the four lamp buses back to a phase code and flags
// bad lamp encodings, conflicting greens and unrecognised patterns.
module tlm_phase_decode
    import tlm_pkg::*;
(
    input  logic [2:0] i_m1,
    input  logic [2:0] i_m2,
    input  logic [2:0] i_mt,
    input  logic [2:0] i_s,
    output logic [2:0] o_phase,
    output logic       o_enc_err,
    output logic       o_conflict,
    output logic       o_unknown
);
    logic [11:0] w_bus;

    assign w_bus = {i_m1, i_m2, i_mt, i_s};

    assign o_phase = (w_bus == {GRN, GRN, RED, RED}) ? P1 :
                     (w_bus == {GRN, YEL, RED, RED}) ? P2 :
                     (w_bus == {GRN, RED, RED, RED}) ? P3 :
                     (w_bus == {YEL, RED, YEL, RED}) ? P4 :
                     (w_bus == {RED, RED, YEL, GRN}) ? P5 :
                     (w_bus == {RED, RED, YEL, RED}) ? P6 : P_NONE;

    assign o_enc_err  = !($onehot(i_m1) && $onehot(i_m2) && $onehot(i_mt) && $onehot(i_s));
    // side street must be red while either main is live; turn must be red while M2 is live
    assign o_conflict = (i_s != RED && (i_m1 != RED || i_m2 != RED)) || (i_mt != RED && i_m2 != RED);
    assign o_unknown  = !o_enc_err && !o_conflict && o_phase == P_NONE;
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: conflict/timing monitor that latches the first lamp fault.
// Optional failsafe flash outputs are enabled with TLM_FLASH_EN.
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int DWELL_P1 = 8,
    parameter int DWELL_P2 = 3,
    parameter int DWELL_P3 = 6,
    parameter int DWELL_P4 = 6,
    parameter int DWELL_P5 = 4,
    parameter int DWELL_P6 = 3,
    parameter int CNT_W    = 5
`ifdef TLM_FLASH_EN
    ,
    parameter int FLASH_DIV = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_M2,
    input  logic [2:0]       light_MT,
    input  logic [2:0]       light_S,
    input  logic             fault_clear,
    output logic [2:0]       phase_o,
    output logic [CNT_W-1:0] dwell_o,
    output logic             in_sync,
    output logic             cycle_done,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [2:0]       fault_phase
`ifdef TLM_FLASH_EN
    ,
    output logic [2:0]       safe_M1,
    output logic [2:0]       safe_M2,
    output logic [2:0]       safe_MT,
    output logic [2:0]       safe_S
`endif
);
    logic [2:0]       w_phase;
    logic             w_enc_err, w_conflict, w_unknown, w_same;
    logic [CNT_W-1:0] w_exp, w_dwell_nxt;
    fault_e           w_seq, w_code;
    state_e           r_state, w_state_nxt;
    logic [2:0]       r_prev;

    tlm_phase_decode u_dec (
        .i_m1      (light_M1),
        .i_m2      (light_M2),
        .i_mt      (light_MT),
        .i_s       (light_S),
        .o_phase   (w_phase),
        .o_enc_err (w_enc_err),
        .o_conflict(w_conflict),
        .o_unknown (w_unknown)
    );

    assign w_exp = (r_prev == P1) ? CNT_W'(DWELL_P1) :
                   (r_prev == P2) ? CNT_W'(DWELL_P2) :
                   (r_prev == P3) ? CNT_W'(DWELL_P3) :
                   (r_prev == P4) ? CNT_W'(DWELL_P4) :
                   (r_prev == P5) ? CNT_W'(DWELL_P5) :
                   (r_prev == P6) ? CNT_W'(DWELL_P6) : '0;

    // dwell restarts at 1 on any phase change and saturates rather than wrapping
    assign w_same      = w_phase == r_prev;
    assign w_dwell_nxt = !w_same ? CNT_W'(1) : (&dwell_o) ? dwell_o : dwell_o + 1'b1;

    assign w_seq = (r_state != TRACK) ? F_NONE :
                   w_same ? ((w_dwell_nxt > w_exp) ? F_LONG : F_NONE) :
                   (w_phase == next_phase(r_prev)) ? ((dwell_o < w_exp) ? F_SHORT : F_NONE) : F_SEQ;

    assign w_code = (r_state == FAULT) ? F_NONE :
                    w_enc_err  ? F_ENC :
                    w_conflict ? F_CONFLICT :
                    w_unknown  ? F_UNKNOWN : w_seq;

    assign w_state_nxt = fault_clear ? SYNC :
                         (w_code != F_NONE) ? FAULT :
                         (r_state == SYNC && w_phase == P1 && r_prev == P6) ? TRACK : r_state;

`ifdef TLM_FLASH_EN
    localparam int FW = $clog2(2 * FLASH_DIV);
    logic [FW-1:0] r_flash, w_flash_nxt;
    logic [2:0]    w_flash_lamp;

    assign w_flash_nxt  = (r_state != FAULT || r_flash == FW'(2 * FLASH_DIV - 1)) ? '0 : r_flash + 1'b1;
    assign w_flash_lamp = (w_flash_nxt < FW'(FLASH_DIV)) ? RED : 3'b000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SYNC;
            r_prev      <= P6;
            phase_o     <= '0;
            dwell_o     <= '0;
            in_sync     <= 1'b0;
            cycle_done  <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= '0;
            fault_phase <= '0;
`ifdef TLM_FLASH_EN
            r_flash     <= '0;
            safe_M1     <= '0;
            safe_M2     <= '0;
            safe_MT     <= '0;
            safe_S      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_phase;
            phase_o    <= w_phase;
            dwell_o    <= w_dwell_nxt;
            in_sync    <= w_state_nxt == TRACK;
            cycle_done <= r_state == TRACK && w_state_nxt == TRACK && r_prev == P6 && w_phase == P1;
            if (fault_clear) begin
                fault       <= 1'b0;
                fault_code  <= '0;
                fault_phase <= '0;
            end else if (w_code != F_NONE) begin
                fault       <= 1'b1;
                fault_code  <= w_code;
                fault_phase <= r_prev;
            end
`ifdef TLM_FLASH_EN
            r_flash <= (w_state_nxt == FAULT) ? w_flash_nxt : '0;
            safe_M1 <= (w_state_nxt == FAULT) ? w_flash_lamp : light_M1;
            safe_M2 <= (w_state_nxt == FAULT) ? w_flash_lamp : light_M2;
            safe_MT <= (w_state_nxt == FAULT) ? w_flash_lamp : light_MT;
            safe_S  <= (w_state_nxt == FAULT) ? w_flash_lamp : light_S;
`endif
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed and randomized checks of the traffic light
// monitor against a rule-level reference model.
module tb_traffic_light_monitor;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    logic       clk, rst, fault_clear;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [2:0] phase_o, fault_code, fault_phase;
    logic [4:0] dwell_o;
    logic       in_sync, cycle_done, fault;
`ifdef TLM_FLASH_EN
    logic [2:0] safe_M1, safe_M2, safe_MT, safe_S;
`endif

    traffic_light_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (light_M1),
        .light_M2   (light_M2),
        .light_MT   (light_MT),
        .light_S    (light_S),
        .fault_clear(fault_clear),
        .phase_o    (phase_o),
        .dwell_o    (dwell_o),
        .in_sync    (in_sync),
        .cycle_done (cycle_done),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_phase(fault_phase)
`ifdef TLM_FLASH_EN
        ,
        .safe_M1    (safe_M1),
        .safe_M2    (safe_M2),
        .safe_MT    (safe_MT),
        .safe_S     (safe_S)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] pat [0:6];
    int req [0:6] = '{0, 8, 3, 6, 6, 4, 3};
    int n_cmp = 0, n_err = 0, cyc = 0;
    int cd_at[$];
    int e_phase, e_dwell, e_prev, e_code, e_fphase;
    bit e_sync, e_fault, e_cd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_phase = 0; e_dwell = 0; e_prev = 6; e_code = 0; e_fphase = 0;
        e_sync = 0; e_fault = 0; e_cd = 0;
    endtask

    // reference: apply the monitor rules to one sample of lamps
    task automatic model(input logic [11:0] l, input bit clr);
        logic [2:0] a [4];
        int p, nd, code;
        a = '{l[11:9], l[8:6], l[5:3], l[2:0]};
        p = 0;
        for (int i = 1; i <= 6; i++) if (pat[i] == l) p = i;
        nd = (p == e_prev) ? ((e_dwell == 31) ? 31 : e_dwell + 1) : 1;
        code = 0;
        if (!e_fault) begin
            if ($countones(a[0]) != 1 || $countones(a[1]) != 1 || $countones(a[2]) != 1 || $countones(a[3]) != 1) code = 1;
            else if ((a[3] != R && (a[0] != R || a[1] != R)) || (a[2] != R && a[1] != R)) code = 2;
            else if (p == 0) code = 3;
            else if (e_sync) begin
                if (p == e_prev) begin
                    if (nd > req[e_prev]) code = 6;
                end else if (p == e_prev % 6 + 1) begin
                    if (e_dwell < req[e_prev]) code = 5;
                end else code = 4;
            end
        end
        e_cd = 0;
        if (clr) begin
            e_fault = 0; e_code = 0; e_fphase = 0; e_sync = 0;
        end else if (code != 0) begin
            e_fault = 1; e_code = code; e_fphase = e_prev; e_sync = 0;
        end else if (!e_fault) begin
            if (e_sync && e_prev == 6 && p == 1) e_cd = 1;
            else if (!e_sync && e_prev == 6 && p == 1) e_sync = 1;
        end
        e_phase = p; e_prev = p; e_dwell = nd;
    endtask

    task automatic step(input logic [11:0] l, input bit clr);
        {light_M1, light_M2, light_MT, light_S} = l;
        fault_clear = clr;
        @(posedge clk);
        #1;
        model(l, clr);
        cyc++;
        if (cycle_done === 1'b1) cd_at.push_back(cyc);
        chk("phase_o", phase_o, e_phase);
        chk("dwell_o", dwell_o, e_dwell);
        chk("in_sync", in_sync, e_sync);
        chk("cycle_done", cycle_done, e_cd);
        chk("fault", fault, e_fault);
        chk("fault_code", fault_code, e_code);
        chk("fault_phase", fault_phase, e_fphase);
    endtask

    task automatic ph(input int p, input int n);
        for (int i = 0; i < n; i++) step(pat[p], 1'b0);
    endtask

    initial begin
        int rp, rrem, r;
        logic [11:0] rl;
        pat = '{12'h000, {G, G, R, R}, {G, Y, R, R}, {G, R, R, R}, {Y, R, Y, R}, {R, R, Y, G}, {R, R, Y, R}};
        {light_M1, light_M2, light_MT, light_S} = pat[1];
        fault_clear = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", phase_o, 0);
        chk("rst_dwell", dwell_o, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_sync", in_sync, 0);
        rst = 1'b0;

        // legal sequence twice, then the next P1
        cyc = 0;
        for (int k = 0; k < 2; k++) for (int p = 1; p <= 6; p++) ph(p, req[p]);
        ph(1, 1);
        chk("cd_count", cd_at.size(), 2);
        if (cd_at.size() == 2) begin
            chk("cd_first", cd_at[0], 31);
            chk("cd_second", cd_at[1], 61);
        end
        chk("legal_fault", fault, 0);

        // bad encoding in TRACK, then code must stay latched
        step({3'b011, G, R, R}, 1'b0);
        chk("enc_code", fault_code, 1);
        ph(1, 2);
        ph(2, 3);
        chk("enc_sticky", fault_code, 1);
        step(pat[1], 1'b1);

        // conflict while in SYNC
        step({G, R, R, G}, 1'b0);
        chk("conflict_code", fault_code, 2);
        step(pat[6], 1'b1);

        // P1 short
        ph(1, 7);
        ph(2, 1);
        chk("short_code", fault_code, 5);
        chk("short_phase", fault_phase, 1);
        step(pat[6], 1'b1);

        // P2 long
        ph(1, 8);
        ph(2, 3);
        chk("p2_ok", fault, 0);
        ph(2, 1);
        chk("long_code", fault_code, 6);
        chk("long_phase", fault_phase, 2);
        step(pat[6], 1'b1);

        // skipped phase, clear mid-P3, resync only at 6->1
        ph(1, 8);
        ph(3, 1);
        chk("seq_code", fault_code, 4);
        step(pat[3], 1'b1);
        chk("clr_fault", fault, 0);
        chk("clr_sync", in_sync, 0);
        ph(3, 5); ph(4, 6); ph(5, 4); ph(6, 3);
        chk("no_early_sync", in_sync, 0);
        ph(1, 1);
        chk("resync", in_sync, 1);

        // clear while mid-P1 must not sync
        step({3'b000, G, R, R}, 1'b0);
        step(pat[1], 1'b1);
        ph(1, 3);
        chk("mid_p1_nosync", in_sync, 0);

        // randomized walk with jitter, stray patterns and clears
        rp = 6; rrem = 0;
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0) rl = 12'($urandom);
            else if (r == 1) rl = pat[$urandom_range(1, 6)];
            else begin
                if (rrem == 0) begin
                    rp = rp % 6 + 1;
                    rrem = req[rp] + (($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) - 1 : 0);
                end
                rl = pat[rp];
                rrem--;
            end
            step(rl, $urandom_range(0, 24) == 0);
        end

        // asynchronous reset mid-operation
        step({3'b110, G, R, R}, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_fault", fault, 0);
        chk("arst_code", fault_code, 0);
        chk("arst_phase", phase_o, 0);
        chk("arst_dwell", dwell_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        ph(6, 1);
        ph(1, 2);

`ifdef TLM_FLASH_EN
        step({3'b000, G, R, R}, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step(pat[1], 1'b0);
            chk("flash_M1", safe_M1, ((k / 4) % 2 == 0) ? R : 3'b000);
            chk("flash_S", safe_S, ((k / 4) % 2 == 0) ? R : 3'b000);
        end
        step(pat[2], 1'b1);
        chk("safe_copy_M2", safe_M2, Y);
        chk("safe_copy_MT", safe_MT, R);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
